// File: rtl/cclut_lut_loader_pkg.sv
// Shared constants, FSM state codes and helpers for the CCLUT LUT loader.
// Holds the address/data/bank/checksum widths used by the loader, its
// per-bank RAM and the write-stream interface.
package cclut_lut_loader_pkg;

  localparam int MXADRB = 12;
  localparam int MXDATB = 9;
  localparam int NPAT   = 5;
  localparam int MXCKB  = 16;
  localparam int PIDW   = 3;
  localparam int VCW    = MXADRB + 1;

  localparam logic [MXADRB-1:0] ADR_LAST = '1;
  localparam logic [PIDW-1:0]   PID_LIM  = PIDW'(NPAT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_CHECK  = 2'd3
  } state_t;

  // Checksum step: zero-extended LUT word added modulo 2^MXCKB.
  function automatic logic [MXCKB-1:0] ck_add(input logic [MXCKB-1:0] s,
                                              input logic [MXDATB-1:0] w);
    return s + MXCKB'(w);
  endfunction

endpackage

// File: rtl/cclut_lut_loader_if.sv
// LUT word write stream from the slow-control path.
//   wr_valid : word present (master -> slave)
//   wr_data  : LUT word {offs[3:0], bend[4:0]} (master -> slave)
//   wr_ready : slave accepts a word this cycle (slave -> master)
interface cclut_lut_loader_if;
  import cclut_lut_loader_pkg::*;

  logic              wr_valid;
  logic [MXDATB-1:0] wr_data;
  logic              wr_ready;

  modport master (output wr_valid, output wr_data, input  wr_ready);
  modport slave  (input  wr_valid, input  wr_data, output wr_ready);
endinterface

// File: rtl/cclut_lut_loader_ram.sv
// One CCLUT pattern bank: 4096 x 9 bit, one write port, two registered read
// ports. Built as two simple-dual-port copies that share the write so each
// read port maps onto its own block RAM.
//   clock  : system clock
//   we     : write enable
//   wa, wd : write address / data
//   ra0/q0 : read port 0 address / registered data (1-clock latency)
//   ra1/q1 : read port 1 address / registered data (1-clock latency)
// Contents are never cleared; the loader's bank_valid gates the outputs.
module cclut_lut_ram
  import cclut_lut_loader_pkg::*;
(
  input  logic              clock,
  input  logic              we,
  input  logic [MXADRB-1:0] wa,
  input  logic [MXDATB-1:0] wd,
  input  logic [MXADRB-1:0] ra0,
  input  logic [MXADRB-1:0] ra1,
  output logic [MXDATB-1:0] q0,
  output logic [MXDATB-1:0] q1
);
  logic [MXDATB-1:0] mem0 [2**MXADRB];
  logic [MXDATB-1:0] mem1 [2**MXADRB];

  always_ff @(posedge clock) begin
    if (we) begin
      mem0[wa] <= wd;
      mem1[wa] <= wd;
    end
    q0 <= mem0[ra0];
    q1 <= mem1[ra1];
  end
endmodule

// File: rtl/cclut_lut_loader.sv
// CCLUT LUT loader: fills one of NPAT pattern banks from a LUT word stream,
// checksums the load, flags the bank valid and serves two lookup ports.
//   clock, reset       : system clock, asynchronous active-high reset
//   cmd_start/cmd_pid  : start loading bank cmd_pid (accepted in IDLE only)
//   cmd_abort          : abandon the current load
//   exp_cksum          : expected checksum of the bank being loaded
//   wr                 : LUT word stream (slave modport), implicit ascending address
//   adr0/adr1          : lookup addresses; rd0_all/rd1_all 1 clock later
//   bank_valid         : bank loaded with matching checksum
//   busy, done, err    : FSM active, good-load pulse, sticky error
//   cksum              : running/final checksum of the current load
// Optional read-back verify pass: define CCLUT_LOADER_VERIFY_EN.
//
// state     | meaning
// ST_IDLE   | waiting for cmd_start
// ST_LOAD   | accepting 4096 words into bank pid
// ST_VERIFY | reading the bank back through port 0 to form vsum
// ST_CHECK  | compare checksum(s), set bank_valid or err
module cclut_lut_loader
  import cclut_lut_loader_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_start,
  input  logic [PIDW-1:0]        cmd_pid,
  input  logic                   cmd_abort,
  input  logic [MXCKB-1:0]       exp_cksum,
  cclut_lut_loader_if.slave      wr,
  input  logic [MXADRB-1:0]      adr0,
  input  logic [MXADRB-1:0]      adr1,
  output logic [NPAT*MXDATB-1:0] rd0_all,
  output logic [NPAT*MXDATB-1:0] rd1_all,
  output logic [NPAT-1:0]        bank_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [MXCKB-1:0]       cksum
);
  state_t            state, state_nxt;
  logic [PIDW-1:0]   pid;
  logic [MXADRB-1:0] adr_cnt;
  logic              start_ok, start_bad, we, pass, fail, chk_ok;
  logic [MXDATB-1:0] q0 [NPAT];
  logic [MXDATB-1:0] q1 [NPAT];

`ifdef CCLUT_LOADER_VERIFY_EN
  localparam logic [VCW-1:0] VCNT_LAST = VCW'(2**MXADRB);
  logic [VCW-1:0]    vcnt;
  logic [MXCKB-1:0]  vsum;
  logic [MXDATB-1:0] q0_sel;

  assign chk_ok = (cksum == exp_cksum) && (vsum == exp_cksum);

  always_comb begin
    q0_sel = '0;
    for (int p = 0; p < NPAT; p++)
      if (pid == PIDW'(p)) q0_sel = q0[p];
  end
`else
  assign chk_ok = (cksum == exp_cksum);
`endif

  assign busy        = (state != ST_IDLE);
  assign wr.wr_ready = (state == ST_LOAD);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    we        = 1'b0;
    pass      = 1'b0;
    fail      = 1'b0;
    case (state)
      ST_IDLE: begin
        // abort in the same cycle drops the start
        if (cmd_start && !cmd_abort) begin
          if (cmd_pid < PID_LIM) begin
            start_ok  = 1'b1;
            state_nxt = ST_LOAD;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (cmd_abort) begin
          fail      = 1'b1;
          state_nxt = ST_IDLE;
        end else if (wr.wr_valid) begin
          we = 1'b1;
          if (adr_cnt == ADR_LAST)
`ifdef CCLUT_LOADER_VERIFY_EN
            state_nxt = ST_VERIFY;
`else
            state_nxt = ST_CHECK;
`endif
        end
      end
`ifdef CCLUT_LOADER_VERIFY_EN
      ST_VERIFY: begin
        if (cmd_abort) begin
          fail      = 1'b1;
          state_nxt = ST_IDLE;
        end else if (vcnt == VCNT_LAST) begin
          state_nxt = ST_CHECK;
        end
      end
`endif
      ST_CHECK: begin
        state_nxt = ST_IDLE;
        if (!cmd_abort && chk_ok) pass = 1'b1;
        else                      fail = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pid        <= '0;
      adr_cnt    <= '0;
      cksum      <= '0;
      bank_valid <= '0;
      err        <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= pass;
      if (start_ok) begin
        pid                 <= cmd_pid;
        adr_cnt             <= '0;
        cksum               <= '0;
        err                 <= 1'b0;
        bank_valid[cmd_pid] <= 1'b0;
      end
      if (start_bad) err <= 1'b1;
      if (we) begin
        cksum   <= ck_add(cksum, wr.wr_data);
        adr_cnt <= adr_cnt + MXADRB'(1);
      end
      if (fail) err <= 1'b1;
      if (pass) bank_valid[pid] <= 1'b1;
    end
  end

`ifdef CCLUT_LOADER_VERIFY_EN
  // q0 in verify cycle n holds address n-1, so the first cycle adds nothing
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vcnt <= '0;
      vsum <= '0;
    end else if (start_ok) begin
      vcnt <= '0;
      vsum <= '0;
    end else if (state == ST_VERIFY) begin
      vcnt <= vcnt + VCW'(1);
      if (vcnt != '0) vsum <= ck_add(vsum, q0_sel);
    end
  end
`endif

  for (genvar p = 0; p < NPAT; p++) begin : g_bank
    logic              bank_sel;
    logic [MXADRB-1:0] ra0;

    assign bank_sel = (pid == PIDW'(p));
`ifdef CCLUT_LOADER_VERIFY_EN
    assign ra0 = (state == ST_VERIFY && bank_sel) ? vcnt[MXADRB-1:0] : adr0;
`else
    assign ra0 = adr0;
`endif

    cclut_lut_ram u_ram (
      .clock (clock),
      .we    (we && bank_sel),
      .wa    (adr_cnt),
      .wd    (wr.wr_data),
      .ra0   (ra0),
      .ra1   (adr1),
      .q0    (q0[p]),
      .q1    (q1[p])
    );

    assign rd0_all[p*MXDATB +: MXDATB] = bank_valid[p] ? q0[p] : '0;
    assign rd1_all[p*MXDATB +: MXDATB] = bank_valid[p] ? q1[p] : '0;
  end
endmodule

// File: tb/tb_cclut_lut_loader.sv
module tb_cclut_lut_loader;
  import cclut_lut_loader_pkg::*;

  localparam int NW = 4096;
`ifdef CCLUT_LOADER_VERIFY_EN
  localparam int LAT = 4098;
`else
  localparam int LAT = 1;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_start = 1'b0;
  logic        cmd_abort = 1'b0;
  logic [2:0]  cmd_pid = '0;
  logic [15:0] exp_cksum = '0;
  logic [11:0] adr0 = '0, adr1 = '0;
  logic [44:0] rd0_all, rd1_all;
  logic [4:0]  bank_valid;
  logic        busy, done, err;
  logic [15:0] cksum;

  cclut_lut_loader_if wr_if();

  cclut_lut_loader u_dut (
    .clock(clock), .reset(reset), .cmd_start(cmd_start), .cmd_pid(cmd_pid),
    .cmd_abort(cmd_abort), .exp_cksum(exp_cksum), .wr(wr_if),
    .adr0(adr0), .adr1(adr1), .rd0_all(rd0_all), .rd1_all(rd1_all),
    .bank_valid(bank_valid), .busy(busy), .done(done), .err(err), .cksum(cksum)
  );

  always #5 clock = ~clock;

  int          n_chk = 0, n_fail = 0, hs_cnt = 0;
  logic [8:0]  model_mem [5][NW];
  logic [4:0]  model_valid = '0;
  logic [11:0] prv0 = '0, prv1 = '0;
  logic [8:0]  wbuf [NW];

  // Expected lookup vector: valid banks return their stored word, others blank.
  function automatic logic [44:0] exp_rd(input logic [11:0] a);
    logic [44:0] r;
    r = '0;
    for (int p = 0; p < 5; p++)
      if (model_valid[p]) r[p*9 +: 9] = model_mem[p][a];
    return r;
  endfunction

  // Advance one clock; lookups driven last cycle are checked against the model.
  task automatic step_cycle();
    if (wr_if.wr_valid && wr_if.wr_ready) hs_cnt++;
    @(negedge clock);
    n_chk++;
    if (rd0_all !== exp_rd(prv0)) begin
      n_fail++; $display("FAIL rd0 adr=%h got=%h exp=%h", prv0, rd0_all, exp_rd(prv0));
    end
    n_chk++;
    if (rd1_all !== exp_rd(prv1)) begin
      n_fail++; $display("FAIL rd1 adr=%h got=%h exp=%h", prv1, rd1_all, exp_rd(prv1));
    end
    n_chk++;
    if (bank_valid !== model_valid) begin
      n_fail++; $display("FAIL bank_valid got=%b exp=%b", bank_valid, model_valid);
    end
    prv0 = 12'($urandom); prv1 = 12'($urandom);
    adr0 = prv0; adr1 = prv1;
  endtask

  // One bank load. ck_delta skews exp_cksum, abort_at>=0 aborts after that many
  // words, hold keeps wr_valid high after the last word, mid_start pulses a
  // start for bank 3 during the load, corrupt flips a RAM bit during VERIFY.
  task automatic do_load(input int pid, input bit adr_pat, input int ck_delta,
                         input int abort_at, input bit gaps, input bit hold,
                         input bit mid_start, input bit corrupt);
    logic [15:0] sum;
    int acc, n;
    bit v, good;
    sum = '0;
    for (int i = 0; i < NW; i++) begin
      wbuf[i] = adr_pat ? 9'(i) : 9'($urandom);
      sum = sum + 16'(wbuf[i]);
      model_mem[pid][i] = wbuf[i];
    end
    exp_cksum = sum + 16'(ck_delta);
    cmd_start = 1'b1; cmd_pid = 3'(pid);
    model_valid[pid] = 1'b0;
    step_cycle();
    cmd_start = 1'b0;
    n_chk++;
    if (busy !== 1'b1 || err !== 1'b0 || wr_if.wr_ready !== 1'b1) begin
      n_fail++; $display("FAIL start pid=%0d busy=%b err=%b ready=%b exp 1/0/1", pid, busy, err, wr_if.wr_ready);
    end
    acc = 0; n = 0;
    while (acc < NW && n < 20000) begin
      if (abort_at >= 0 && acc == abort_at) break;
      v = !gaps || ($urandom_range(0, 3) != 0);
      wr_if.wr_valid = v; wr_if.wr_data = wbuf[acc];
      cmd_start = mid_start && (n == 2000);
      cmd_pid   = mid_start && (n == 2000) ? 3'd3 : 3'(pid);
      n_chk++;
      if (wr_if.wr_ready !== 1'b1) begin
        n_fail++; $display("FAIL ready_in_load word=%0d got=%b exp=1", acc, wr_if.wr_ready);
      end
      if (v) acc++;
      step_cycle(); n++;
      cmd_start = 1'b0;
      n_chk++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_fail++; $display("FAIL load_status word=%0d busy=%b done=%b exp 1/0", acc, busy, done);
      end
    end
    if (abort_at >= 0) begin
      wr_if.wr_valid = 1'b0; cmd_abort = 1'b1;
      step_cycle();
      cmd_abort = 1'b0;
      n_chk++;
      if (busy !== 1'b0 || err !== 1'b1 || done !== 1'b0) begin
        n_fail++; $display("FAIL abort busy=%b err=%b done=%b exp 0/1/0", busy, err, done);
      end
      return;
    end
    wr_if.wr_valid = hold;
    n_chk++;
    if (wr_if.wr_ready !== 1'b0 || cksum !== sum || busy !== 1'b1) begin
      n_fail++; $display("FAIL after_last ready=%b cksum=%h busy=%b exp 0/%h/1", wr_if.wr_ready, cksum, busy, sum);
    end
    good = (ck_delta == 0) && !corrupt;
    for (int cnt = 1; cnt <= LAT + 1; cnt++) begin
`ifdef CCLUT_LOADER_VERIFY_EN
      if (corrupt && cnt == 5)
        u_dut.g_bank[4].u_ram.mem0[12'd3000] <= u_dut.g_bank[4].u_ram.mem0[12'd3000] ^ 9'h001;
`endif
      if (cnt == LAT && good) model_valid[pid] = 1'b1;
      step_cycle();
      n_chk++;
      if (done !== (good && cnt == LAT) || busy !== (cnt < LAT) ||
          err !== ((cnt >= LAT) && !good) || wr_if.wr_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL finish cnt=%0d done=%b busy=%b err=%b ready=%b exp %b/%b/%b/0", cnt,
                 done, busy, err, wr_if.wr_ready, good && cnt == LAT, cnt < LAT, (cnt >= LAT) && !good);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_chk++;
    if (wr_if.wr_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
        cksum !== 16'h0 || bank_valid !== 5'h0 || rd0_all !== 45'h0 || rd1_all !== 45'h0) begin
      n_fail++; $display("FAIL reset ready=%b busy=%b done=%b err=%b cksum=%h bv=%b rd0=%h rd1=%h exp all 0",
                         wr_if.wr_ready, busy, done, err, cksum, bank_valid, rd0_all, rd1_all);
    end
    reset = 1'b0;
    step_cycle();
  endtask

  task automatic test_good_load();
    do_load(2, 1'b1, 0, -1, 1'b0, 1'b0, 1'b0, 1'b0);
    adr0 = 12'h1FF; prv0 = 12'h1FF;
    step_cycle();
    n_chk++;
    if (rd0_all[2*9 +: 9] !== 9'h1FF || bank_valid !== 5'b00100) begin
      n_fail++; $display("FAIL good_load slice2=%h bv=%b exp 1ff/00100", rd0_all[2*9 +: 9], bank_valid);
    end
  endtask

  task automatic test_bad_cksum();
    do_load(2, 1'b1, 1, -1, 1'b0, 1'b0, 1'b0, 1'b0);
    adr0 = 12'h1FF; prv0 = 12'h1FF;
    step_cycle();
    n_chk++;
    if (rd0_all[2*9 +: 9] !== 9'h000 || bank_valid[2] !== 1'b0 || err !== 1'b1) begin
      n_fail++; $display("FAIL bad_cksum slice2=%h bv2=%b err=%b exp 000/0/1", rd0_all[2*9 +: 9], bank_valid[2], err);
    end
  endtask

  task automatic test_bad_pid();
    cmd_start = 1'b1; cmd_pid = 3'd5;
    step_cycle();
    cmd_start = 1'b0;
    n_chk++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bad_pid err=%b busy=%b exp 1/0", err, busy);
    end
    step_cycle();
    n_chk++;
    if (busy !== 1'b0 || bank_valid !== model_valid) begin
      n_fail++; $display("FAIL bad_pid_idle busy=%b bv=%b exp 0/%b", busy, bank_valid, model_valid);
    end
    do_load(3, 1'b0, 0, -1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    do_load(0, 1'b0, 0, 100, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (20) step_cycle();
    n_chk++;
    if (bank_valid[0] !== 1'b0 || bank_valid[3] !== 1'b1 || err !== 1'b1) begin
      n_fail++; $display("FAIL abort_after bv=%b err=%b exp bv0=0 bv3=1 err=1", bank_valid, err);
    end
    cmd_start = 1'b1; cmd_abort = 1'b1; cmd_pid = 3'd0;
    step_cycle();
    cmd_start = 1'b0; cmd_abort = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || err !== 1'b1) begin
      n_fail++; $display("FAIL abort_with_start busy=%b err=%b exp 0/1", busy, err);
    end
  endtask

  task automatic test_hold_valid();
    hs_cnt = 0;
    do_load(1, 1'b0, 0, -1, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 104; i++) begin
      step_cycle();
      n_chk++;
      if (wr_if.wr_ready !== 1'b0) begin
        n_fail++; $display("FAIL hold_ready cyc=%0d got=%b exp=0", i, wr_if.wr_ready);
      end
    end
    wr_if.wr_valid = 1'b0;
    n_chk++;
    if (hs_cnt !== NW) begin
      n_fail++; $display("FAIL hold_count got=%0d exp=%0d", hs_cnt, NW);
    end
  endtask

  task automatic test_back_to_back();
    do_load(0, 1'b0, 0, -1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_load(2, 1'b0, 0, -1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (50) step_cycle();
    n_chk++;
    if (bank_valid !== 5'b01111) begin
      n_fail++; $display("FAIL back_to_back bv=%b exp=01111", bank_valid);
    end
  endtask

`ifdef CCLUT_LOADER_VERIFY_EN
  task automatic test_verify_corrupt();
    do_load(4, 1'b0, 0, -1, 1'b0, 1'b0, 1'b0, 1'b1);
    n_chk++;
    if (err !== 1'b1 || bank_valid[4] !== 1'b0) begin
      n_fail++; $display("FAIL verify_corrupt err=%b bv4=%b exp 1/0", err, bank_valid[4]);
    end
  endtask
`endif

  initial begin
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = '0;
    test_reset();
    test_good_load();
    test_bad_cksum();
    test_bad_pid();
    test_abort();
    test_hold_valid();
    test_back_to_back();
`ifdef CCLUT_LOADER_VERIFY_EN
    test_verify_corrupt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
